// File: rtl/fault_campaign_ctrl.sv
// Sequences one fault-injection experiment: reset, chain shift, load, run, compare.
// Golden and faulty netlist outputs are compared one cycle behind the run enable.
module fault_campaign_ctrl #(
    parameter int NUM_SITES = 64,
    parameter int IDX_W     = $clog2(NUM_SITES),
    parameter int OUT_W     = 16,
    parameter int CYC_W     = 16,
    parameter int CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] fault_site_idx,
    input  logic [CYC_W-1:0] run_cycles,
    input  logic [OUT_W-1:0] golden_out,
    input  logic [OUT_W-1:0] faulty_out,
    output logic             dut_rst_n,
    output logic             chain_en,
    output logic             chain_sdi,
    output logic             chain_load,
    output logic             dut_run,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] err_count,
    output logic             err_seen,
    output logic [CYC_W-1:0] first_err_cyc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SHIFT,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CYC_W-1:0] LAST_SHIFT = CYC_W'(NUM_SITES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CYC_W-1:0]   cnt;
    logic [CYC_W-1:0]   cnt_nxt;
    logic               abort_go;
    logic               accept;
    logic [IDX_W-1:0]   idx_q;
    logic [CYC_W-1:0]   run_q;
    logic               in_range;
    logic [CYC_W-1:0]   sdi_pos;
    logic               sdi_nxt;
    logic               cmp_v;
    logic [CYC_W-1:0]   cmp_idx;
    logic               mismatch;

    assign accept   = (state == S_IDLE) && start && !abort;
    assign in_range = ({1'b0, idx_q} < (IDX_W + 1)'(NUM_SITES));
    // Chain is shifted MSB first, so site idx lands on shift cycle NUM_SITES-1-idx.
    assign sdi_pos  = LAST_SHIFT - CYC_W'(idx_q);
    assign sdi_nxt  = (state_nxt == S_SHIFT) && in_range && (cnt_nxt == sdi_pos);
    assign mismatch = cmp_v && (golden_out != faulty_out);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        abort_go  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_RST;
                    cnt_nxt   = '0;
                end
            end
            S_RST: begin
                state_nxt = S_SHIFT;
                cnt_nxt   = '0;
            end
            S_SHIFT: begin
                if (cnt == LAST_SHIFT) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CYC_W'(1);
                end
            end
            S_LOAD: begin
                cnt_nxt   = '0;
                state_nxt = (run_q == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (cnt == run_q - CYC_W'(1)) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CYC_W'(1);
                end
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Abort overrides every normal transition, including the one into LOAD.
        if (abort && (state != S_IDLE) && (state != S_DONE)) begin
            state_nxt = S_DONE;
            cnt_nxt   = '0;
            abort_go  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            run_q      <= '0;
            dut_rst_n  <= 1'b1;
            chain_en   <= 1'b0;
            chain_sdi  <= 1'b0;
            chain_load <= 1'b0;
            dut_run    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dut_rst_n  <= (state_nxt != S_RST);
            chain_en   <= (state_nxt == S_SHIFT);
            chain_sdi  <= sdi_nxt;
            chain_load <= (state_nxt == S_LOAD);
            dut_run    <= (state_nxt == S_RUN);
            busy       <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_DONE);
            aborted    <= abort_go;
            if (accept) begin
                idx_q <= fault_site_idx;
                run_q <= run_cycles;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            cmp_v         <= 1'b0;
            cmp_idx       <= '0;
            err_count     <= '0;
            err_seen      <= 1'b0;
            first_err_cyc <= '0;
        end else begin
            cmp_v   <= dut_run;
            cmp_idx <= cnt;
            if (accept) begin
                err_count     <= '0;
                err_seen      <= 1'b0;
                first_err_cyc <= '0;
            end else if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + CNT_W'(1);
                end
                if (!err_seen) begin
                    err_seen      <= 1'b1;
                    first_err_cyc <= cmp_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Testbench for fault_campaign_ctrl: directed vector table, random experiments
// against a cycle-arithmetic model, plus reset and idle-input corner sequences.
module tb_fault_campaign_ctrl;

    localparam int NS = 64;
    // One extra index bit so out-of-range sites (>= NS) can be requested.
    localparam int IW = 7;
    localparam int OW = 16;
    localparam int CW = 16;
    localparam int NW = 32;

    logic          CLK = 1'b0;
    logic          RSTB = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [IW-1:0] fault_site_idx = '0;
    logic [CW-1:0] run_cycles = '0;
    logic [OW-1:0] golden_out = '0;
    logic [OW-1:0] faulty_out = '0;
    logic          dut_rst_n;
    logic          chain_en;
    logic          chain_sdi;
    logic          chain_load;
    logic          dut_run;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [NW-1:0] err_count;
    logic          err_seen;
    logic [CW-1:0] first_err_cyc;

    fault_campaign_ctrl #(
        .NUM_SITES(NS), .IDX_W(IW), .OUT_W(OW), .CYC_W(CW), .CNT_W(NW)
    ) dut (
        .CLK(CLK), .RSTB(RSTB), .start(start), .abort(abort),
        .fault_site_idx(fault_site_idx), .run_cycles(run_cycles),
        .golden_out(golden_out), .faulty_out(faulty_out),
        .dut_rst_n(dut_rst_n), .chain_en(chain_en), .chain_sdi(chain_sdi),
        .chain_load(chain_load), .dut_run(dut_run), .busy(busy), .done(done),
        .aborted(aborted), .err_count(err_count), .err_seen(err_seen),
        .first_err_cyc(first_err_cyc)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          idx;
        int          rc;
        logic [63:0] mm;
        int          abort_t;
        bit          dstart;
        int          e_done;
        int          e_ab;
        int          e_shift;
        int          e_sdi;
        int          e_load;
        int          e_runs;
        int          e_err;
        int          e_seen;
        int          e_first;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    vec_t tbl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Timeline counted in cycles after the accept edge: RST at t=1, shift k at
    // t=2+k, LOAD at t=66, run j at t=67+j, DRAIN, then DONE at t=68+rc.
    function automatic vec_t model(input int idx, input int rc,
                                   input logic [63:0] mm, input int at,
                                   input bit ds);
        vec_t v;
        v.idx = idx; v.rc = rc; v.mm = mm; v.abort_t = at; v.dstart = ds;
        if (at == 0) begin
            v.e_done = 68 + rc; v.e_ab = 0; v.e_shift = NS;
            v.e_load = 1; v.e_runs = rc;
        end else begin
            v.e_done  = at + 1;
            v.e_ab    = 1;
            v.e_shift = (at < 2) ? 0 : ((at - 1 > NS) ? NS : at - 1);
            v.e_load  = (at >= 66) ? 1 : 0;
            v.e_runs  = (at < 67) ? 0 : ((at - 66 > rc) ? rc : at - 66);
        end
        v.e_sdi = (idx < NS && (NS - 1 - idx) < v.e_shift) ? NS - 1 - idx : -1;
        v.e_err = 0; v.e_seen = 0; v.e_first = 0;
        for (int j = 0; j < v.e_runs && j < 64; j++) begin
            if (mm[j]) begin
                if (v.e_seen == 0) v.e_first = j;
                v.e_seen = 1;
                v.e_err++;
            end
        end
        return v;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, " dut_rst_n"}, dut_rst_n, 1);
        chk({tag, " ctrl_outs"},
            {chain_en, chain_sdi, chain_load, dut_run, busy, done, aborted}, 0);
        chk({tag, " err_count"}, err_count, 0);
        chk({tag, " err_seen"}, err_seen, 0);
        chk({tag, " first_err"}, first_err_cyc, 0);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int t = 0, ks = 0, sdi_first = -1, sdi_ones = 0;
        int loads = 0, runs = 0, rsts = 0, done_t = -1, ab = 0, excl = 0;
        int extra = 0;
        string p;
        p = $sformatf("v%0d", n);
        @(negedge CLK);
        fault_site_idx = IW'(v.idx);
        run_cycles = CW'(v.rc);
        start = 1'b1;
        while (t < 300 && done_t < 0) begin
            @(negedge CLK);
            t++;
            start = v.dstart && (t == 30);
            abort = (v.abort_t != 0) && (t == v.abort_t);
            golden_out = OW'($urandom);
            faulty_out = golden_out;
            if (t >= 68 && t - 68 < 64 && v.mm[t-68])
                faulty_out = golden_out ^ OW'($urandom_range(1, 65535));
            if (!dut_rst_n) rsts++;
            if (chain_en) begin
                if (chain_sdi) begin
                    sdi_ones++;
                    if (sdi_first < 0) sdi_first = ks;
                end
                ks++;
            end
            if (chain_load) loads++;
            if (dut_run) runs++;
            if (int'(chain_en) + int'(chain_load) + int'(dut_run) + int'(!dut_rst_n) > 1)
                excl++;
            if (done) begin
                done_t = t;
                ab = int'(aborted);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        faulty_out = golden_out;
        @(negedge CLK);
        chk({p, " busy_after"}, busy, 0);
        chk({p, " err_count"}, err_count, v.e_err);
        chk({p, " err_seen"}, err_seen, v.e_seen);
        if (v.e_seen != 0) chk({p, " first_err"}, first_err_cyc, v.e_first);
        repeat (3) begin
            if (done) extra++;
            @(negedge CLK);
        end
        chk({p, " done_t"}, done_t, v.e_done);
        chk({p, " aborted"}, ab, v.e_ab);
        chk({p, " rst_cycles"}, rsts, 1);
        chk({p, " shifts"}, ks, v.e_shift);
        chk({p, " sdi_pos"}, sdi_first, v.e_sdi);
        chk({p, " sdi_ones"}, sdi_ones, (v.e_sdi >= 0) ? 1 : 0);
        chk({p, " loads"}, loads, v.e_load);
        chk({p, " runs"}, runs, v.e_runs);
        chk({p, " exclusive"}, excl, 0);
        chk({p, " extra_done"}, extra, 0);
    endtask

    function automatic vec_t dv(input int idx, input int rc, input logic [63:0] mm,
                                input int at, input bit ds, input int d, input int ab,
                                input int sh, input int sdi, input int ld, input int rn,
                                input int er, input int sn, input int fi);
        vec_t v;
        v.idx = idx; v.rc = rc; v.mm = mm; v.abort_t = at; v.dstart = ds;
        v.e_done = d; v.e_ab = ab; v.e_shift = sh; v.e_sdi = sdi; v.e_load = ld;
        v.e_runs = rn; v.e_err = er; v.e_seen = sn; v.e_first = fi;
        return v;
    endfunction

    initial begin
        int t;
        vec_t v;
        // idx rc mm abort dstart | done ab shift sdi load runs err seen first
        tbl.push_back(dv(5, 10, 64'h0, 0, 0, 78, 0, 64, 58, 1, 10, 0, 0, 0));
        tbl.push_back(dv(0, 8, 64'h48, 0, 0, 76, 0, 64, 63, 1, 8, 2, 1, 3));
        tbl.push_back(dv(12, 0, 64'hFF, 0, 0, 68, 0, 64, 51, 1, 0, 0, 0, 0));
        tbl.push_back(dv(9, 5, 64'h0, 22, 0, 23, 1, 21, -1, 0, 0, 0, 0, 0));
        tbl.push_back(dv(70, 4, 64'h0, 0, 1, 72, 0, 64, -1, 1, 4, 0, 0, 0));
        tbl.push_back(dv(3, 20, 64'h8024, 74, 0, 75, 1, 64, 60, 1, 8, 2, 1, 2));
        tbl.push_back(dv(63, 1, 64'h1, 0, 0, 69, 0, 64, 0, 1, 1, 1, 1, 0));

        repeat (3) @(negedge CLK);
        check_reset_vals("reset");
        RSTB = 1'b1;

        @(negedge CLK);
        start = 1'b1;
        abort = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle busy", busy, 0);
        @(negedge CLK);
        chk("start_abort_idle dut_rst_n", dut_rst_n, 1);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort_idle done", {busy, done, aborted}, 0);

        foreach (tbl[i]) run_vec(i, tbl[i]);

        for (int n = 0; n < 10; n++) begin
            int at;
            at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 65)) : 0;
            v = model(int'($urandom_range(0, 127)), int'($urandom_range(0, 40)),
                      {$urandom, $urandom}, at, 1'($urandom_range(0, 1)));
            run_vec(100 + n, v);
        end

        // Reset in the middle of RUN after one counted mismatch.
        @(negedge CLK);
        fault_site_idx = IW'(2);
        run_cycles = CW'(30);
        start = 1'b1;
        t = 0;
        while (t < 78) begin
            @(negedge CLK);
            t++;
            start = 1'b0;
            golden_out = OW'($urandom);
            faulty_out = (t == 69) ? ~golden_out : golden_out;
        end
        chk("midrun dut_run", dut_run, 1);
        chk("midrun err_count", err_count, 1);
        RSTB = 1'b0;
        @(negedge CLK);
        check_reset_vals("midrun_rst");
        RSTB = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            chk("post_rst no_done", {done, busy}, 0);
        end
        run_vec(200, tbl[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
